// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding, reset PC default, stride.
package instruction_fetch_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_STRIDE     = 32'd4;

  // Branch displacement: word offset sign-extended to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: instruction memory request/ack plus the decoder-side hold/accept handshake.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        jr;
  logic        branch_taken;
  logic [31:0] jr_addr;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_out, link_addr, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, jump, jr, branch_taken, jr_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_out, link_addr, fetch_err,
    output imem_ack, imem_rdata, instr_ready, jump, jr, branch_taken, jr_addr
  );
endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the held instruction: jr > jump > branch > sequential.
module pc_next_logic
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic        jump,
  input  logic        jr,
  input  logic        branch_taken,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output logic [31:0] link_addr,
  output logic        jr_misaligned
);

  assign link_addr     = pc + INSTR_STRIDE;
  assign jr_misaligned = jr & (|jr_addr[1:0]);

  always_comb begin
    next_pc = link_addr;
    if (jr) begin
      next_pc = {jr_addr[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {link_addr[31:28], instr_idx, 2'b00};
    end else if (branch_taken) begin
      next_pc = link_addr + branch_offset(instr_idx[15:0]);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: requests the word at PC, holds it for decode, then steps to the next PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;
  logic [31:0] link_addr;
  logic        jr_misaligned;

  pc_next_logic u_pc_next (
    .pc            (pc_q),
    .instr_idx     (instr_q[25:0]),
    .jump          (bus.jump),
    .jr            (bus.jr),
    .branch_taken  (bus.branch_taken),
    .jr_addr       (bus.jr_addr),
    .next_pc       (next_pc),
    .link_addr     (link_addr),
    .jr_misaligned (jr_misaligned)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Control inputs only matter in the cycle the decoder accepts.
        if (bus.instr_ready) begin
          pc_d    = next_pc;
          state_d = REQ;
          if (jr_misaligned) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.pc_out      = pc_q;
  assign bus.link_addr   = link_addr;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: driver issues fetches, monitor scores held instructions.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] link;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic exp_err = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic valid_prev = 1'b0;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.instr_ready  = 1'b0;
    bus.jump         = 1'b0;
    bus.jr           = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jr_addr      = 32'h0;
  endtask

  // Entered just after a negedge; leaves just after the negedge following acceptance.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int ack_dly,
                          input int rdy_dly, input logic j, input logic r, input logic b,
                          input logic [31:0] ja);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'h0, bus.imem_req}, 32'h1);
    check("fetch_addr", bus.imem_addr, addr);
    check("fetch_err", {31'h0, bus.fetch_err}, {31'h0, exp_err});
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      check("wait_addr", bus.imem_addr, addr);
      check("wait_valid", {31'h0, bus.instr_valid}, 32'h0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    sb_q.push_back('{instr: data, pc: addr, link: addr + 32'd4});
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("ack_latency_valid", {31'h0, bus.instr_valid}, 32'h1);
    for (int i = 0; i < rdy_dly; i++) begin
      // Stray ack and control with ready low must not disturb the held state.
      bus.imem_ack     = 1'b1;
      bus.imem_rdata   = ~data;
      bus.jump         = 1'b1;
      bus.jr           = 1'b1;
      bus.branch_taken = 1'b1;
      bus.jr_addr      = 32'h0000_0003;
      @(negedge clk);
      check("stall_instr", bus.instr, data);
      check("stall_pc", bus.pc_out, addr);
      check("stall_req", {31'h0, bus.imem_req}, 32'h0);
    end
    clear_inputs();
    bus.instr_ready  = 1'b1;
    bus.jump         = j;
    bus.jr           = r;
    bus.branch_taken = b;
    bus.jr_addr      = ja;
    @(negedge clk);
    clear_inputs();
    if (r && (ja[1:0] != 2'b00)) exp_err = 1'b1;
  endtask

  always @(negedge clk) begin
    if (bus.instr_valid && !valid_prev) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got instr %h expected none", bus.instr);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_instr", bus.instr, mon_e.instr);
        check("sb_pc", bus.pc_out, mon_e.pc);
        check("sb_link", bus.link_addr, mon_e.link);
      end
    end
    valid_prev = bus.instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #3;
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_link", bus.link_addr, 32'h4);
    check("rst_err", {31'h0, bus.fetch_err}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_fetch(32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0004, 32'h2222_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0008, 32'h1234_5678, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_000C, 32'h0000_0000, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
    do_fetch(32'h0000_0040, 32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0);
    do_fetch(32'h0000_0040, 32'h0800_0040, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0100, 32'h1000_FFFF, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0);
    do_fetch(32'h0000_0100, 32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0203);
    do_fetch(32'h0000_0200, 32'h0000_0000, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'hABCD_0123, 0, 5, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a request at address 0, then a late ack.
    check("pre_rst_req", {31'h0, bus.imem_req}, 32'h1);
    check("pre_rst_addr", bus.imem_addr, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("async_req_drop", {31'h0, bus.imem_req}, 32'h0);
    check("async_err_clear", {31'h0, bus.fetch_err}, 32'h0);
    check("async_instr", bus.instr, 32'h0);
    check("async_link", bus.link_addr, 32'h4);
    exp_err = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("late_ack_valid", {31'h0, bus.instr_valid}, 32'h0);
    check("late_ack_req", {31'h0, bus.imem_req}, 32'h1);

    do_fetch(32'h0000_0000, 32'hCAFE_F00D, 2, 1, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0004, 32'h0000_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("final_addr", bus.imem_addr, 32'h0000_0008);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
